// File: rtl/brg_ram_pkg.sv
// Shared types and helpers for the byte-write RMW dual-port RAM.
// Provides port FSM states and the lane-select overlay function.
package brg_ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } port_state_e;

  // Widest word / lane count lane_merge can handle; callers
  // zero-extend into these widths and truncate the result.
  localparam int LM_W = 1024;
  localparam int LM_C = 128;

  // Bits of lanes whose we bit is set come from new_w, the rest
  // from old_w.
  function automatic logic [LM_W-1:0] lane_merge(
    input logic [LM_W-1:0] old_w,
    input logic [LM_W-1:0] new_w,
    input logic [LM_C-1:0] we,
    input int              col_w
  );
    logic [LM_W-1:0] r;
    r = old_w;
    for (int i = 0; i < LM_W; i++) begin
      if (((i / col_w) < LM_C) && we[i / col_w])
        r[i] = new_w[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpram_word.sv
// Word-write true dual-port RAM, 1-cycle read-first, no reset.
// Ports: clk; per port en/we/addr/din in, dout out.
module dpram_word #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          ena,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  output logic [DW-1:0] douta,
  input  logic          enb,
  input  logic          web,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dinb,
  output logic [DW-1:0] doutb
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (ena) douta <= mem[addra];
    if (enb) doutb <= mem[addrb];
    if (enb && web) mem[addrb] <= dinb;
    if (ena && wea) mem[addra] <= dina;
  end

endmodule

// File: rtl/bytew_rmw_dpram.sv
// Byte-lane write dual-port RAM built by read-modify-write on a
// word-write RAM. Ports A/B: en/we/addr/din in; ready/dout/dout_vld out.
module bytew_rmw_dpram
  import brg_ram_pkg::*;
#(
  parameter  int NUM_COL    = 4,
  parameter  int COL_WIDTH  = 8,
  parameter  int ADDR_WIDTH = 8,
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enA,
  input  logic [NUM_COL-1:0]    weA,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [DATA_WIDTH-1:0] dinA,
  output logic                  readyA,
  output logic [DATA_WIDTH-1:0] doutA,
  output logic                  doutA_vld,
  input  logic                  enB,
  input  logic [NUM_COL-1:0]    weB,
  input  logic [ADDR_WIDTH-1:0] addrB,
  input  logic [DATA_WIDTH-1:0] dinB,
  output logic                  readyB,
  output logic [DATA_WIDTH-1:0] doutB,
  output logic                  doutB_vld
);

  localparam int NC = NUM_COL;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  port_state_e stA_q, stA_d, stB_q, stB_d;
  logic [AW-1:0] adA_q, adA_d, adB_q, adB_d;
  logic [DW-1:0] dnA_q, dnA_d, dnB_q, dnB_d;
  logic [NC-1:0] weA_q, weA_d, weB_q, weB_d;
  logic [NC-1:0] fwA_q, fwA_d, fwB_q, fwB_d;
  logic [DW-1:0] fdA_q, fdA_d, fdB_q, fdB_d;
  logic          rdA_q, rdA_d, rdB_q, rdB_d;
  logic [DW-1:0] hdA_q, hdA_d, hdB_q, hdB_d;
  logic          rdy_q;

  logic wrA, fullA, partA, wrB, fullB, partB;
  logic blkA, blkB, accA, accB;
  logic          mA_en, mA_we, mB_en, mB_we;
  logic [AW-1:0] mA_ad, mB_ad;
  logic [DW-1:0] mA_di, mB_di, mA_do, mB_do;
  logic [DW-1:0] fwdA, fwdB, mgA, mgB;

  assign wrA   = |weA;
  assign fullA = &weA;
  assign partA = wrA && !fullA;
  assign wrB   = |weB;
  assign fullB = &weB;
  assign partB = wrB && !fullB;

  // A pending merge owns its address for the commit cycle.
  assign blkA = (stB_q == MERGE) && enA && wrA
             && (addrA == adB_q);
  assign readyA = rdy_q && (stA_q == IDLE) && !blkA;
  assign accA   = enA && readyA;

  // Besides merge ownership, B yields to A when both would
  // write the same word directly, or both start an RMW on it
  // (two merges would collide on the next cycle).
  assign blkB = ((stA_q == MERGE) && enB && wrB
              && (addrB == adA_q))
             || (accA && enB && (addrB == addrA)
              && ((fullA && fullB) || (partA && partB)));
  assign readyB = rdy_q && (stB_q == IDLE) && !blkB;
  assign accB   = enB && readyB;

  // Old word, patched by the other port's same-cycle write,
  // then overlaid with the port's own lanes.
  assign fwdA = DW'(lane_merge(LM_W'(mA_do), LM_W'(fdA_q),
                               LM_C'(fwA_q), COL_WIDTH));
  assign mgA  = DW'(lane_merge(LM_W'(fwdA), LM_W'(dnA_q),
                               LM_C'(weA_q), COL_WIDTH));
  assign fwdB = DW'(lane_merge(LM_W'(mB_do), LM_W'(fdB_q),
                               LM_C'(fwB_q), COL_WIDTH));
  assign mgB  = DW'(lane_merge(LM_W'(fwdB), LM_W'(dnB_q),
                               LM_C'(weB_q), COL_WIDTH));

  assign mA_en = accA || (stA_q == MERGE);
  assign mA_we = (accA && fullA) || (stA_q == MERGE);
  assign mA_ad = (stA_q == MERGE) ? adA_q : addrA;
  assign mA_di = (stA_q == MERGE) ? mgA : dinA;

  assign mB_en = accB || (stB_q == MERGE);
  assign mB_we = (accB && fullB) || (stB_q == MERGE);
  assign mB_ad = (stB_q == MERGE) ? adB_q : addrB;
  assign mB_di = (stB_q == MERGE) ? mgB : dinB;

  // RAM dout also moves on RMW reads, so completed read data
  // is held separately.
  assign doutA     = rdA_q ? mA_do : hdA_q;
  assign doutA_vld = rdA_q;
  assign doutB     = rdB_q ? mB_do : hdB_q;
  assign doutB_vld = rdB_q;

  always_comb begin
    stA_d = stA_q;
    adA_d = adA_q;
    dnA_d = dnA_q;
    weA_d = weA_q;
    fwA_d = fwA_q;
    fdA_d = fdA_q;
    rdA_d = accA && !wrA;
    hdA_d = rdA_q ? mA_do : hdA_q;
    unique case (stA_q)
      IDLE: begin
        if (accA && partA) begin
          stA_d = MERGE;
          adA_d = addrA;
          dnA_d = dinA;
          weA_d = weA;
          fwA_d = {NC{mB_we && (mB_ad == addrA)}};
          fdA_d = mB_di;
        end
      end
      MERGE:   stA_d = IDLE;
      default: stA_d = IDLE;
    endcase
  end

  always_comb begin
    stB_d = stB_q;
    adB_d = adB_q;
    dnB_d = dnB_q;
    weB_d = weB_q;
    fwB_d = fwB_q;
    fdB_d = fdB_q;
    rdB_d = accB && !wrB;
    hdB_d = rdB_q ? mB_do : hdB_q;
    unique case (stB_q)
      IDLE: begin
        if (accB && partB) begin
          stB_d = MERGE;
          adB_d = addrB;
          dnB_d = dinB;
          weB_d = weB;
          fwB_d = {NC{mA_we && (mA_ad == addrB)}};
          fdB_d = mA_di;
        end
      end
      MERGE:   stB_d = IDLE;
      default: stB_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stA_q <= IDLE;
      stB_q <= IDLE;
      adA_q <= '0;
      adB_q <= '0;
      dnA_q <= '0;
      dnB_q <= '0;
      weA_q <= '0;
      weB_q <= '0;
      fwA_q <= '0;
      fwB_q <= '0;
      fdA_q <= '0;
      fdB_q <= '0;
      rdA_q <= 1'b0;
      rdB_q <= 1'b0;
      hdA_q <= '0;
      hdB_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      stA_q <= stA_d;
      stB_q <= stB_d;
      adA_q <= adA_d;
      adB_q <= adB_d;
      dnA_q <= dnA_d;
      dnB_q <= dnB_d;
      weA_q <= weA_d;
      weB_q <= weB_d;
      fwA_q <= fwA_d;
      fwB_q <= fwB_d;
      fdA_q <= fdA_d;
      fdB_q <= fdB_d;
      rdA_q <= rdA_d;
      rdB_q <= rdB_d;
      hdA_q <= hdA_d;
      hdB_q <= hdB_d;
      rdy_q <= 1'b1;
    end
  end

`ifdef behav_sim
  dpram_word #(.DW(DW), .AW(AW)) u_ram_sim (
    .clk  (clk),
    .ena  (mA_en),
    .wea  (mA_we),
    .addra(mA_ad),
    .dina (mA_di),
    .douta(mA_do),
    .enb  (mB_en),
    .web  (mB_we),
    .addrb(mB_ad),
    .dinb (mB_di),
    .doutb(mB_do)
  );
`else
  dpram_word #(.DW(DW), .AW(AW)) u_ram (
    .clk  (clk),
    .ena  (mA_en),
    .wea  (mA_we),
    .addra(mA_ad),
    .dina (mA_di),
    .douta(mA_do),
    .enb  (mB_en),
    .web  (mB_we),
    .addrb(mB_ad),
    .dinb (mB_di),
    .doutb(mB_do)
  );
`endif

endmodule
